event_counter_bank: RTL and testbench
=====================================

// Module: event_counter_bank
// PURPOSE
//   Parametrised bank of NCH independent event counters, each WIDTH bits: per-channel count enable,
//   wrap/saturate mode, sticky overflow, parallel load, simultaneous snapshot of all channels into
//   shadow registers, and 1-cycle-latency indexed readout of the shadow bank. Sits between hit/event
//   strobes from the datapath and the register/readout interface (rate, error and trigger counters).
// PARAMETERS
//   NCH     8    number of counter channels (1..64)
//   WIDTH   32   counter width in bits (2..64)
//   CH_W    ($clog2(NCH)>0 ? $clog2(NCH) : 1)   channel index width (derived, do not override)
// PORTS
//   clk        in   1        single clock; all logic on posedge
//   rst        in   1        synchronous, active-high reset
//   inc        in   NCH      per-channel event strobe; one count per cycle while high
//   sat_mode   in   1        1: saturate at all-ones; 0: wrap to 0 (quasi-static, sampled each cycle)
//   clr        in   1        clear all counters and overflow flags
//   ld_en      in   1        load ld_val into channel ld_ch
//   ld_ch      in   CH_W     load target channel
//   ld_val     in   WIDTH    load value
//   snap       in   1        copy all live counters + ovf flags into shadow bank
//   snap_done  out  1        1-cycle pulse, cycle after snap accepted
//   rd_req     in   1        read request for shadow channel rd_ch
//   rd_ch      in   CH_W     read index
//   rd_valid   out  1        1-cycle pulse, cycle after rd_req
//   rd_data    out  WIDTH    shadow count of rd_ch (held until next rd_valid)
//   rd_ovf     out  1        shadow overflow flag of rd_ch
//   rd_err     out  1        asserted with rd_valid when rd_ch >= NCH (rd_data=0, rd_ovf=0)
//   ovf        out  NCH      live sticky overflow flags
// BEHAVIOUR
//   - Reset: all counters, shadows, ovf, rd_data, rd_ovf, rd_err, rd_valid, snap_done = 0.
//   - Per-channel update priority, per cycle: rst > clr > ld_en (ld_ch==ch) > inc[ch] > hold.
//   - inc at cnt < all-ones: cnt+1. inc at all-ones: ovf[ch] set; cnt -> 0 (sat_mode=0) or held
//     at all-ones (sat_mode=1). ovf sticky; cleared only by rst or clr; load does not clear ovf.
//   - ld_en with ld_ch >= NCH: ignored, no channel changes. inc on the loaded channel in the same
//     cycle is dropped (load wins).
//   - snap: shadow[ch] <= live cnt/ovf as registered before this edge (pre-update); an inc, load or
//     clr in the snap cycle affects live counters only. snap and clr together: shadow gets pre-clear
//     values, live cleared. snap_done pulses next cycle. Back-to-back snaps each accepted.
//   - Read: rd_req at cycle N -> rd_valid, rd_data, rd_ovf, rd_err at N+1 from shadow as of end of
//     N (snap in N is visible to a read in N+1, not N). rd_req every cycle sustained: one result per
//     cycle. Outputs hold last value when rd_valid is low.
//   - Arithmetic unsigned, WIDTH bits; no X propagation from out-of-range indices.
// CONFIGURATION
//   EVCNT_PRESCALE_EN defined: adds parameter PRESC_W (default 8) and input presc_div [PRESC_W-1:0];
//     each channel has a PRESC_W prescaler; counter advances once per (presc_div+1) inc strobes.
//     Prescalers reset by rst/clr and the channel's ld_en; not snapshotted. presc_div=0 == bypass.
//   Not defined: no prescaler logic or port; every inc strobe advances the counter.
// STRUCTURE
//   evcnt_pkg: CH_W derivation function, update-priority encoding constants, max-value constant.
//   Sub-module evcnt_channel: one counter + ovf + (optional) prescaler; bank instantiates NCH in a
//   generate loop; snapshot shadow and readout mux live in event_counter_bank.
// TESTING (NCH=4, WIDTH=8 unless noted)
//   1 rst, then inc[0] high 10 cycles, snap, rd_req ch0 -> rd_data=10, rd_ovf=0, rd_valid 1 cycle later.
//   2 ld ch1=0xFE, sat_mode=0, 3 inc -> cnt=0x01, ovf[1]=1; repeat sat_mode=1 -> cnt=0xFF, ovf[1]=1.
//   3 ld_en ch2=0x20 and inc[2] same cycle -> 0x20; ld_ch=5 (NCH=6 build, ld_ch=7) -> no change.
//   4 snap+clr+inc[3] same cycle with ch3=7 -> shadow ch3=7, live ch3=0, ovf all 0.
//   5 rd_req rd_ch=5 on NCH=4/CH_W=3 build -> rd_valid=1, rd_err=1, rd_data=0; continuous rd_req 0..3.
//   6 EVCNT_PRESCALE_EN, presc_div=3, 12 inc on ch0 -> cnt=3; rst mid-run -> all zero next cycle.

Source files
------------

// File: rtl/evcnt_pkg.sv
// Shared types and helpers for the event counter bank.
// Optional prescaler build: define EVCNT_PRESCALE_EN.
package evcnt_pkg;

  localparam int EVCNT_MAX_NCH = 64;
  localparam int EVCNT_MAX_W   = 64;

  typedef enum logic [1:0] {
    UPD_HOLD = 2'd0,
    UPD_INC  = 2'd1,
    UPD_LOAD = 2'd2,
    UPD_CLR  = 2'd3
  } upd_t;

  function automatic int evcnt_ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic [EVCNT_MAX_W-1:0] evcnt_max(
    input int w
  );
    logic [EVCNT_MAX_W-1:0] one;
    one = 1;
    if (w >= EVCNT_MAX_W) return '1;
    return (one << w) - one;
  endfunction

endpackage

// File: rtl/evcnt_channel.sv
// One event counter with sticky overflow and optional prescaler.
// Optional prescaler build: define EVCNT_PRESCALE_EN.
module evcnt_channel
  import evcnt_pkg::*;
#(
  parameter int WIDTH = 32
`ifdef EVCNT_PRESCALE_EN
 ,parameter int PRESC_W = 8
`endif
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               ld,
  input  logic [WIDTH-1:0]   ld_val,
  input  logic               inc,
  input  logic               sat_mode,
`ifdef EVCNT_PRESCALE_EN
  input  logic [PRESC_W-1:0] presc_div,
`endif
  output logic [WIDTH-1:0]   cnt,
  output logic               ovf
);

  localparam logic [WIDTH-1:0] CNT_MAX =
    WIDTH'(evcnt_max(WIDTH));

  logic step;
  upd_t upd;

`ifdef EVCNT_PRESCALE_EN
  logic [PRESC_W-1:0] presc_q;

  assign step = inc && (presc_q >= presc_div);

  // Divide inc strobes; restarts whenever the counter is cleared or loaded
  always_ff @(posedge clk) begin
    if (rst || clr || ld) begin
      presc_q <= '0;
    end else if (inc) begin
      presc_q <= step ? '0 : presc_q + 1'b1;
    end
  end
`else
  assign step = inc;
`endif

  // Update priority: clear, then load, then counting
  always_comb begin
    upd = UPD_HOLD;
    if (clr) begin
      upd = UPD_CLR;
    end else if (ld) begin
      upd = UPD_LOAD;
    end else if (step) begin
      upd = UPD_INC;
    end
  end

  // Counter and sticky overflow state
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      ovf <= 1'b0;
    end else begin
      case (upd)
        UPD_CLR: begin
          cnt <= '0;
          ovf <= 1'b0;
        end
        UPD_LOAD: cnt <= ld_val;
        UPD_INC: begin
          if (cnt == CNT_MAX) begin
            ovf <= 1'b1;
            if (!sat_mode) cnt <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/event_counter_bank.sv
// Bank of event counters with snapshot shadows and indexed readout.
// Optional prescaler build: define EVCNT_PRESCALE_EN.
module event_counter_bank
  import evcnt_pkg::*;
#(
  parameter int NCH   = 8,
  parameter int WIDTH = 32,
`ifdef EVCNT_PRESCALE_EN
  parameter int PRESC_W = 8,
`endif
  parameter int CH_W  = evcnt_ch_w(NCH)
) (
  input  logic               clk,
  input  logic               rst,
`ifdef EVCNT_PRESCALE_EN
  input  logic [PRESC_W-1:0] presc_div,
`endif
  input  logic [NCH-1:0]     inc,
  input  logic               sat_mode,
  input  logic               clr,
  input  logic               ld_en,
  input  logic [CH_W-1:0]    ld_ch,
  input  logic [WIDTH-1:0]   ld_val,
  input  logic               snap,
  output logic               snap_done,
  input  logic               rd_req,
  input  logic [CH_W-1:0]    rd_ch,
  output logic               rd_valid,
  output logic [WIDTH-1:0]   rd_data,
  output logic               rd_ovf,
  output logic               rd_err,
  output logic [NCH-1:0]     ovf
);

  localparam logic [CH_W:0] NCH_V = (CH_W+1)'(NCH);

  logic [WIDTH-1:0] cnt    [NCH];
  logic [WIDTH-1:0] sh_cnt [NCH];
  logic [NCH-1:0]   sh_ovf;

  logic             rd_hit;
  logic [WIDTH-1:0] rd_cnt_mux;
  logic             rd_ovf_mux;

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    evcnt_channel #(
      .WIDTH   (WIDTH)
`ifdef EVCNT_PRESCALE_EN
     ,.PRESC_W (PRESC_W)
`endif
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .clr       (clr),
      .ld        (ld_en && (ld_ch == CH_W'(g))),
      .ld_val    (ld_val),
      .inc       (inc[g]),
      .sat_mode  (sat_mode),
`ifdef EVCNT_PRESCALE_EN
      .presc_div (presc_div),
`endif
      .cnt       (cnt[g]),
      .ovf       (ovf[g])
    );
  end

  // Capture pre-update live state into the shadow bank
  always_ff @(posedge clk) begin
    if (rst) begin
      snap_done <= 1'b0;
      sh_ovf    <= '0;
      for (int i = 0; i < NCH; i++) sh_cnt[i] <= '0;
    end else begin
      snap_done <= snap;
      if (snap) begin
        sh_ovf <= ovf;
        for (int i = 0; i < NCH; i++) sh_cnt[i] <= cnt[i];
      end
    end
  end

  // Shadow readout mux; out-of-range indices select nothing
  always_comb begin
    rd_hit     = ({1'b0, rd_ch} < NCH_V);
    rd_cnt_mux = '0;
    rd_ovf_mux = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      if (rd_ch == CH_W'(i)) begin
        rd_cnt_mux = sh_cnt[i];
        rd_ovf_mux = sh_ovf[i];
      end
    end
  end

  // Registered read response, held between requests
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
      rd_ovf   <= 1'b0;
      rd_err   <= 1'b0;
    end else begin
      rd_valid <= rd_req;
      if (rd_req) begin
        rd_data <= rd_cnt_mux;
        rd_ovf  <= rd_ovf_mux;
        rd_err  <= !rd_hit;
      end
    end
  end

endmodule

// File: tb/tb_event_counter_bank.sv
// Directed scoreboard bench for event_counter_bank.
// Prescaler steps build only with EVCNT_PRESCALE_EN.
module tb_event_counter_bank;

  localparam int NCH   = 4;
  localparam int WIDTH = 8;
  localparam int CH_W  = 3;

  typedef struct {
    logic [WIDTH-1:0] d;
    logic             o;
    logic             e;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [NCH-1:0]   inc = '0;
  logic             sat_mode = 1'b0;
  logic             clr = 1'b0;
  logic             ld_en = 1'b0;
  logic [CH_W-1:0]  ld_ch = '0;
  logic [WIDTH-1:0] ld_val = '0;
  logic             snap = 1'b0;
  logic             snap_done;
  logic             rd_req = 1'b0;
  logic [CH_W-1:0]  rd_ch = '0;
  logic             rd_valid;
  logic [WIDTH-1:0] rd_data;
  logic             rd_ovf;
  logic             rd_err;
  logic [NCH-1:0]   ovf;
`ifdef EVCNT_PRESCALE_EN
  logic [7:0]       presc_div = '0;
`endif

  int   passed = 0;
  int   failed = 0;
  int   total  = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  event_counter_bank #(
    .NCH   (NCH),
    .WIDTH (WIDTH),
    .CH_W  (CH_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
`ifdef EVCNT_PRESCALE_EN
    .presc_div (presc_div),
`endif
    .inc       (inc),
    .sat_mode  (sat_mode),
    .clr       (clr),
    .ld_en     (ld_en),
    .ld_ch     (ld_ch),
    .ld_val    (ld_val),
    .snap      (snap),
    .snap_done (snap_done),
    .rd_req    (rd_req),
    .rd_ch     (rd_ch),
    .rd_valid  (rd_valid),
    .rd_data   (rd_data),
    .rd_ovf    (rd_ovf),
    .rd_err    (rd_err),
    .ovf       (ovf)
  );

  task automatic chk(
    input string       tag,
    input logic [63:0] obs,
    input logic [63:0] exp
  );
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(
    input logic [WIDTH-1:0] d,
    input logic             o,
    input logic             e
  );
    exp_t x;
    x.d = d;
    x.o = o;
    x.e = e;
    sb.push_back(x);
  endtask

  task automatic rd(
    input int               ch,
    input logic [WIDTH-1:0] d,
    input logic             o,
    input logic             e
  );
    rd_req = 1'b1;
    rd_ch  = CH_W'(ch);
    push(d, o, e);
    tick();
    rd_req = 1'b0;
  endtask

  task automatic ld(
    input int               ch,
    input logic [WIDTH-1:0] v
  );
    ld_en  = 1'b1;
    ld_ch  = CH_W'(ch);
    ld_val = v;
    tick();
    ld_en  = 1'b0;
  endtask

  task automatic do_snap();
    snap = 1'b1;
    tick();
    snap = 1'b0;
  endtask

  // Compare every read response against the oldest expectation
  always @(negedge clk) begin
    exp_t e;
    if (rd_valid) begin
      if (sb.size() == 0) begin
        chk("rd_unexpected", 64'd1, 64'd0);
      end else begin
        e = sb.pop_front();
        chk("rd_data", 64'(rd_data), 64'(e.d));
        chk("rd_ovf", 64'(rd_ovf), 64'(e.o));
        chk("rd_err", 64'(rd_err), 64'(e.e));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_ovf", 64'(ovf), 64'd0);
    chk("rst_rd_valid", 64'(rd_valid), 64'd0);
    chk("rst_snap_done", 64'(snap_done), 64'd0);
    chk("rst_rd_data", 64'(rd_data), 64'd0);
    chk("rst_rd_err", 64'(rd_err), 64'd0);

    inc = 4'b0001;
    repeat (10) tick();
    inc = '0;
    snap = 1'b1;
    tick();
    snap = 1'b0;
    chk("snap_done_pulse", 64'(snap_done), 64'd1);
    rd(0, 8'd10, 1'b0, 1'b0);
    chk("snap_done_drop", 64'(snap_done), 64'd0);

    sat_mode = 1'b0;
    ld(1, 8'hFE);
    inc = 4'b0010;
    repeat (3) tick();
    inc = '0;
    chk("wrap_ovf", 64'(ovf), 64'b0010);
    do_snap();
    rd(1, 8'h01, 1'b1, 1'b0);

    sat_mode = 1'b1;
    ld(1, 8'hFE);
    inc = 4'b0010;
    repeat (3) tick();
    inc = '0;
    chk("sat_ovf", 64'(ovf), 64'b0010);
    do_snap();
    rd(1, 8'hFF, 1'b1, 1'b0);
    sat_mode = 1'b0;

    ld_en  = 1'b1;
    ld_ch  = 3'd2;
    ld_val = 8'h20;
    inc    = 4'b0100;
    tick();
    ld_en  = 1'b0;
    inc    = '0;
    ld(7, 8'h55);
    ld(4, 8'h66);
    do_snap();
    rd(2, 8'h20, 1'b0, 1'b0);
    rd(0, 8'd10, 1'b0, 1'b0);
    rd(3, 8'h00, 1'b0, 1'b0);
    rd(1, 8'hFF, 1'b1, 1'b0);

    ld(3, 8'h07);
    snap = 1'b1;
    clr  = 1'b1;
    inc  = 4'b1000;
    tick();
    snap = 1'b0;
    clr  = 1'b0;
    inc  = '0;
    chk("clr_snap_done", 64'(snap_done), 64'd1);
    chk("clr_ovf", 64'(ovf), 64'd0);
    rd(3, 8'h07, 1'b0, 1'b0);
    rd(1, 8'hFF, 1'b1, 1'b0);
    do_snap();
    rd(3, 8'h00, 1'b0, 1'b0);
    rd(1, 8'h00, 1'b0, 1'b0);

    ld(1, 8'h33);
    ld(2, 8'h44);
    inc = 4'b0001;
    repeat (5) tick();
    inc = '0;
    snap   = 1'b1;
    rd_req = 1'b1;
    rd_ch  = 3'd0;
    push(8'h00, 1'b0, 1'b0);
    tick();
    snap = 1'b0;
    push(8'h05, 1'b0, 1'b0);
    tick();
    rd_req = 1'b0;

    rd(5, 8'h00, 1'b0, 1'b1);
    rd(7, 8'h00, 1'b0, 1'b1);

    rd_req = 1'b1;
    for (int i = 0; i < NCH; i++) begin
      rd_ch = CH_W'(i);
      case (i)
        0:       push(8'h05, 1'b0, 1'b0);
        1:       push(8'h33, 1'b0, 1'b0);
        2:       push(8'h44, 1'b0, 1'b0);
        default: push(8'h00, 1'b0, 1'b0);
      endcase
      tick();
    end
    rd_req = 1'b0;

    rd(2, 8'h44, 1'b0, 1'b0);
    tick();
    chk("hold_rd_valid", 64'(rd_valid), 64'd0);
    chk("hold_rd_data", 64'(rd_data), 64'h44);
    chk("hold_rd_err", 64'(rd_err), 64'd0);

    ld(2, 8'hFF);
    inc = 4'b0100;
    tick();
    chk("ovf_before_rst", 64'(ovf), 64'b0100);
    inc = 4'b1111;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    inc = '0;
    chk("midrst_ovf", 64'(ovf), 64'd0);
    chk("midrst_rd_data", 64'(rd_data), 64'd0);
    chk("midrst_snap_done", 64'(snap_done), 64'd0);
    do_snap();
    rd(2, 8'h00, 1'b0, 1'b0);
    rd(0, 8'h00, 1'b0, 1'b0);

`ifdef EVCNT_PRESCALE_EN
    presc_div = 8'd3;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    inc = 4'b0001;
    repeat (12) tick();
    inc = '0;
    do_snap();
    rd(0, 8'd3, 1'b0, 1'b0);
    inc = 4'b0001;
    repeat (6) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    inc = '0;
    chk("presc_rst_ovf", 64'(ovf), 64'd0);
    do_snap();
    rd(0, 8'd0, 1'b0, 1'b0);
    presc_div = 8'd0;
`endif

    for (int i = 0; i < 20 && sb.size() > 0; i++) tick();
    chk("sb_drain", 64'(sb.size()), 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
